mem_bus_arbiter: RTL and testbench

- Shares the single memory port (mem_ce/mem_w/mem_r/mem_oe, addr_bus, data_bus) between two bus masters.
- m0 is the cpu control unit, doing fetch and load/store. m1 is the program loader/DMA, doing boot image writes and LED/IO buffer copies.
- Arbitrates one transfer at a time, drives the memory strobes for a fixed access latency, returns read data and a one-cycle ack to the winner.

---
 rtl/scpu_bus_pkg.sv | 16 +
 rtl/arb_rr_pick.sv | 30 +++
 rtl/mem_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scpu_bus_pkg.sv
// Shared bus types and constants for the single-port memory arbiter and the cpu top.
package scpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } arb_state_t;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way requester picker: round robin on a tie, or m0-first when ARB_FIXED_PRIO_EN is defined.
module arb_rr_pick
  import scpu_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner,
  output logic       valid
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    valid  = |req;
    winner = REQ_M0;
    if (req == 2'b11) begin
`ifdef ARB_FIXED_PRIO_EN
      winner = REQ_M0;
`else
      winner = ~last_grant;
`endif
    end else if (req[REQ_M1]) begin
      winner = REQ_M1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the cpu control unit (m0) and the loader/DMA (m1).
// Tie policy is round robin unless ARB_FIXED_PRIO_EN is defined (see arb_rr_pick).
module mem_bus_arbiter
  import scpu_bus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_ce,
  output logic              mem_w,
  output logic              mem_r,
  output logic              mem_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("mem_bus_arbiter: MEM_LAT must be in 1..15");
  end

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  arb_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic              m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
  logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic              mem_ce_q, mem_ce_d, mem_w_q, mem_w_d;
  logic              mem_r_q, mem_r_d, mem_oe_q, mem_oe_d;
  logic              pick_win, pick_vld;

  arb_rr_pick u_pick (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant_q),
    .winner     (pick_win),
    .valid      (pick_vld)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    m0_gnt_d     = m0_gnt_q;
    m1_gnt_d     = m1_gnt_q;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    mem_ce_d     = mem_ce_q;
    mem_w_d      = mem_w_q;
    mem_r_d      = mem_r_q;
    mem_oe_d     = mem_oe_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d      = pick_win;
          last_grant_d = pick_win;
          we_d         = (pick_win == REQ_M1) ? m1_we    : m0_we;
          mem_addr_d   = (pick_win == REQ_M1) ? m1_addr  : m0_addr;
          mem_wdata_d  = (pick_win == REQ_M1) ? m1_wdata : m0_wdata;
          m0_gnt_d     = (pick_win == REQ_M0);
          m1_gnt_d     = (pick_win == REQ_M1);
          cnt_d        = LAT_LOAD;
          // Strobes are registered, so they rise together with the ACCESS state.
          mem_ce_d     = 1'b1;
          mem_w_d      = we_d;
          mem_r_d      = ~we_d;
          mem_oe_d     = ~we_d;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (owner_q == REQ_M0) m0_rdata_d = mem_rdata;
            else                   m1_rdata_d = mem_rdata;
          end
          mem_ce_d = 1'b0;
          mem_w_d  = 1'b0;
          mem_r_d  = 1'b0;
          mem_oe_d = 1'b0;
          m0_ack_d = (owner_q == REQ_M0);
          m1_ack_d = (owner_q == REQ_M1);
          state_d  = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        m0_gnt_d = 1'b0;
        m1_gnt_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= REQ_M1;
      owner_q      <= REQ_M0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      m0_gnt_q     <= 1'b0;
      m1_gnt_q     <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      mem_ce_q     <= 1'b0;
      mem_w_q      <= 1'b0;
      mem_r_q      <= 1'b0;
      mem_oe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      m0_gnt_q     <= m0_gnt_d;
      m1_gnt_q     <= m1_gnt_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      mem_ce_q     <= mem_ce_d;
      mem_w_q      <= mem_w_d;
      mem_r_q      <= mem_r_d;
      mem_oe_q     <= mem_oe_d;
    end
  end

  assign m0_gnt    = m0_gnt_q;
  assign m1_gnt    = m1_gnt_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign mem_ce    = mem_ce_q;
  assign mem_w     = mem_w_q;
  assign mem_r     = mem_r_q;
  assign mem_oe    = mem_oe_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: instance 0 uses MEM_LAT=1, instance 1 uses MEM_LAT=3.
module tb_mem_bus_arbiter;

`ifdef ARB_FIXED_PRIO_EN
  localparam int ALT_M = 0;
`else
  localparam int ALT_M = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n;
  logic [1:0]       m0_req, m0_we, m0_gnt, m0_ack;
  logic [1:0]       m1_req, m1_we, m1_gnt, m1_ack;
  logic [1:0][15:0] m0_addr, m1_addr, mem_addr;
  logic [1:0][7:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic [1:0]       mem_ce, mem_w, mem_r, mem_oe;
  logic [1:0][7:0]  mem_wdata, rd_val;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n[0]),
    .m0_req(m0_req[0]), .m0_we(m0_we[0]), .m0_addr(m0_addr[0]), .m0_wdata(m0_wdata[0]),
    .m0_gnt(m0_gnt[0]), .m0_ack(m0_ack[0]), .m0_rdata(m0_rdata[0]),
    .m1_req(m1_req[0]), .m1_we(m1_we[0]), .m1_addr(m1_addr[0]), .m1_wdata(m1_wdata[0]),
    .m1_gnt(m1_gnt[0]), .m1_ack(m1_ack[0]), .m1_rdata(m1_rdata[0]),
    .mem_ce(mem_ce[0]), .mem_w(mem_w[0]), .mem_r(mem_r[0]), .mem_oe(mem_oe[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(rd_val[0])
  );

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n[1]),
    .m0_req(m0_req[1]), .m0_we(m0_we[1]), .m0_addr(m0_addr[1]), .m0_wdata(m0_wdata[1]),
    .m0_gnt(m0_gnt[1]), .m0_ack(m0_ack[1]), .m0_rdata(m0_rdata[1]),
    .m1_req(m1_req[1]), .m1_we(m1_we[1]), .m1_addr(m1_addr[1]), .m1_wdata(m1_wdata[1]),
    .m1_gnt(m1_gnt[1]), .m1_ack(m1_ack[1]), .m1_rdata(m1_rdata[1]),
    .mem_ce(mem_ce[1]), .mem_w(mem_w[1]), .mem_r(mem_r[1]), .mem_oe(mem_oe[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(rd_val[1])
  );

  typedef struct {
    int         master;
    logic [7:0] rd0;
    logic [7:0] rd1;
  } exp_t;

  exp_t            sbq0[$], sbq1[$];
  logic [1:0][7:0] exp_rd0, exp_rd1;
  int              ack_seen [2];
  int              checks = 0;
  int              errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected rdata of both masters after this transfer's ack, per instance.
  task automatic sb_push(input int inst, input int master, input bit is_read, input logic [7:0] val);
    exp_t e;
    if (is_read) begin
      if (master == 0) exp_rd0[inst] = val;
      else             exp_rd1[inst] = val;
    end
    e.master = master;
    e.rd0    = exp_rd0[inst];
    e.rd1    = exp_rd1[inst];
    if (inst == 0) sbq0.push_back(e);
    else           sbq1.push_back(e);
  endtask

  task automatic monitor(input int i);
    exp_t e;
    chk($sformatf("gnt_excl%0d", i), {30'd0, m0_gnt[i] & m1_gnt[i]}, 32'd0);
    chk($sformatf("ack_wo_gnt%0d", i),
        {30'd0, (m0_ack[i] & ~m0_gnt[i]) | (m1_ack[i] & ~m1_gnt[i])}, 32'd0);
    if (m0_ack[i] | m1_ack[i]) begin
      ack_seen[i]++;
      if ((i == 0 && sbq0.size() == 0) || (i == 1 && sbq1.size() == 0)) begin
        chk($sformatf("unexpected_ack%0d", i), {30'd0, m1_ack[i], m0_ack[i]}, 32'd0);
      end else begin
        e = (i == 0) ? sbq0.pop_front() : sbq1.pop_front();
        chk($sformatf("ack_master%0d", i), {30'd0, m1_ack[i], m0_ack[i]},
            (e.master == 1) ? 32'd2 : 32'd1);
        chk($sformatf("m0_rdata%0d", i), {24'd0, m0_rdata[i]}, {24'd0, e.rd0});
        chk($sformatf("m1_rdata%0d", i), {24'd0, m1_rdata[i]}, {24'd0, e.rd1});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor(0);
    monitor(1);
  endtask

  task automatic run_acks(input int inst, input int n, input int bound);
    int tgt;
    int k;
    tgt = ack_seen[inst] + n;
    k   = 0;
    while (ack_seen[inst] < tgt && k < bound) begin
      tick();
      k++;
    end
    chk($sformatf("ack_timeout%0d", inst), {31'd0, ack_seen[inst] >= tgt}, 32'd1);
    m0_req[inst] = 1'b0;
    m1_req[inst] = 1'b0;
  endtask

  function automatic logic [3:0] strobes(input int i);
    return {mem_ce[i], mem_w[i], mem_r[i], mem_oe[i]};
  endfunction

  initial begin
    int wcnt;
    int acnt;
    rst_n = 2'b00;
    m0_req = '0; m0_we = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = '0; m1_we = '0; m1_addr = '0; m1_wdata = '0;
    rd_val = '0; exp_rd0 = '0; exp_rd1 = '0;
    ack_seen[0] = 0; ack_seen[1] = 0;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_strobes", {28'd0, strobes(i)}, 32'd0);
      chk("rst_gnt_ack", {28'd0, m0_gnt[i], m1_gnt[i], m0_ack[i], m1_ack[i]}, 32'd0);
      chk("rst_addr", {16'd0, mem_addr[i]}, 32'd0);
      chk("rst_data", {8'd0, mem_wdata[i], m0_rdata[i], m1_rdata[i]}, 32'd0);
    end
    rst_n = 2'b11;
    tick();

    // Single read, MEM_LAT=1
    m0_addr[0] = 16'h0010; m0_we[0] = 1'b0; rd_val[0] = 8'hA5;
    sb_push(0, 0, 1'b1, 8'hA5);
    m0_req[0] = 1'b1;
    tick();
    chk("t1_strobes", {28'd0, strobes(0)}, 32'hB);
    chk("t1_addr", {16'd0, mem_addr[0]}, 32'h0010);
    chk("t1_gnt", {31'd0, m0_gnt[0]}, 32'd1);
    chk("t1_ack_early", {31'd0, m0_ack[0]}, 32'd0);
    tick();
    chk("t1_ack", {31'd0, m0_ack[0]}, 32'd1);
    chk("t1_strobes_off", {28'd0, strobes(0)}, 32'd0);
    m0_req[0] = 1'b0;
    tick();
    chk("t1_ack_once", {31'd0, m0_ack[0]}, 32'd0);
    chk("t1_gnt_off", {31'd0, m0_gnt[0]}, 32'd0);
    chk("t1_rdata_hold", {24'd0, m0_rdata[0]}, 32'hA5);

    // Single write, MEM_LAT=3
    m1_addr[1] = 16'h8001; m1_wdata[1] = 8'h3C; m1_we[1] = 1'b1;
    sb_push(1, 1, 1'b0, 8'h00);
    m1_req[1] = 1'b1;
    wcnt = 0; acnt = 0;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (mem_w[1]) begin
        wcnt++;
        chk("t2_wdata", {24'd0, mem_wdata[1]}, 32'h3C);
        chk("t2_addr", {16'd0, mem_addr[1]}, 32'h8001);
      end
      if (m1_ack[1]) begin
        acnt++;
        m1_req[1] = 1'b0;
      end
    end
    chk("t2_wlen", wcnt, 32'd3);
    chk("t2_acks", acnt, 32'd1);

    // Tie from reset on instance 0
    rst_n[0] = 1'b0;
    tick();
    exp_rd0[0] = 8'h00; exp_rd1[0] = 8'h00;
    rst_n[0] = 1'b1;
    chk("t3_rst_rdata", {24'd0, m0_rdata[0]}, 32'd0);
    rd_val[0] = 8'h11;
    m0_addr[0] = 16'h0100; m1_addr[0] = 16'h0200; m0_we[0] = 1'b0; m1_we[0] = 1'b0;
    sb_push(0, 0, 1'b1, 8'h11);
    sb_push(0, ALT_M, 1'b1, 8'h11);
    sb_push(0, 0, 1'b1, 8'h11);
    sb_push(0, ALT_M, 1'b1, 8'h11);
    m0_req[0] = 1'b1; m1_req[0] = 1'b1;
    run_acks(0, 4, 20);
    tick();
    tick();

    // Late requester held off until the next IDLE
    m0_addr[0] = 16'h0030; rd_val[0] = 8'h42;
    sb_push(0, 0, 1'b1, 8'h42);
    m0_req[0] = 1'b1;
    tick();
    chk("t4_m0_gnt", {31'd0, m0_gnt[0]}, 32'd1);
    m1_addr[0] = 16'h0040; m1_req[0] = 1'b1;
    tick();
    chk("t4_m0_ack", {31'd0, m0_ack[0]}, 32'd1);
    chk("t4_m1_held", {31'd0, m1_gnt[0]}, 32'd0);
    m0_req[0] = 1'b0;
    tick();
    chk("t4_idle_gnt", {30'd0, m0_gnt[0], m1_gnt[0]}, 32'd0);
    chk("t4_idle_strobes", {28'd0, strobes(0)}, 32'd0);
    rd_val[0] = 8'h24;
    sb_push(0, 1, 1'b1, 8'h24);
    tick();
    chk("t4_m1_gnt", {31'd0, m1_gnt[0]}, 32'd1);
    chk("t4_m1_addr", {16'd0, mem_addr[0]}, 32'h0040);
    chk("t4_m1_strobes", {28'd0, strobes(0)}, 32'hB);
    tick();
    chk("t4_m1_ack", {31'd0, m1_ack[0]}, 32'd1);
    m1_req[0] = 1'b0;
    tick();

    // Reset lands in the 2nd ACCESS cycle of a MEM_LAT=3 write
    m0_addr[1] = 16'h1234; m0_wdata[1] = 8'h99; m0_we[1] = 1'b1;
    m0_req[1] = 1'b1;
    tick();
    tick();
    chk("t5_mid_write", {28'd0, strobes(1)}, 32'hC);
    rst_n[1] = 1'b0;
    tick();
    chk("t5_strobes", {28'd0, strobes(1)}, 32'd0);
    chk("t5_gnt_ack", {28'd0, m0_gnt[1], m1_gnt[1], m0_ack[1], m1_ack[1]}, 32'd0);
    chk("t5_addr_data", {8'd0, mem_addr[1], mem_wdata[1]}, 32'd0);
    m0_req[1] = 1'b0;
    exp_rd0[1] = 8'h00; exp_rd1[1] = 8'h00;
    rst_n[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t5_no_ack", {30'd0, m0_ack[1], m1_ack[1]}, 32'd0);
    end
    rd_val[1] = 8'h5E;
    m0_we[1] = 1'b0; m1_we[1] = 1'b0;
    m0_addr[1] = 16'h0300; m1_addr[1] = 16'h0400;
    sb_push(1, 0, 1'b1, 8'h5E);
    sb_push(1, ALT_M, 1'b1, 8'h5E);
    m0_req[1] = 1'b1; m1_req[1] = 1'b1;
    run_acks(1, 2, 20);
    tick();
    tick();

    // Request withdrawn during ACCESS; latched values still used
    m0_addr[1] = 16'h0020; m0_we[1] = 1'b0; rd_val[1] = 8'h77;
    sb_push(1, 0, 1'b1, 8'h77);
    m0_req[1] = 1'b1;
    tick();
    chk("t6_addr", {16'd0, mem_addr[1]}, 32'h0020);
    m0_req[1] = 1'b0; m0_addr[1] = 16'hFFFF; m0_we[1] = 1'b1;
    tick();
    chk("t6_addr_latched", {16'd0, mem_addr[1]}, 32'h0020);
    chk("t6_strobes", {28'd0, strobes(1)}, 32'hB);
    run_acks(1, 1, 6);
    tick();
    tick();
    chk("t6_rdata", {24'd0, m0_rdata[1]}, 32'h77);

    chk("sb_empty0", sbq0.size(), 32'd0);
    chk("sb_empty1", sbq1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
